lpf_fir31: RTL and testbench

Sequential 31-tap low-pass FIR engine that consumes the 31x10 signed coefficient ROM (Wn=.0075 set, coefficients scaled by 2**10, sum 1021). It accepts one signed 8-bit audio sample per sample strobe, stores it in a 32-entry circular history buffer, and runs one multiply-accumulate per clock, indexing the ROM directly. It sits between the sample-rate decimation/capture stage and downstream envelope/display logic, producing one filtered 18-bit result per accepted sample.

---
 rtl/lpf_fir31_if.sv | 20 ++
 rtl/lpf_fir31.sv | 112 +++++++++++
 tb/tb_lpf_fir31.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lpf_fir31_if.sv
// Sample/result bus of the 31-tap low-pass FIR engine, including the coefficient ROM lookup.
// The overrun signal exists only when FIR_OVERRUN_FLAG_EN is defined.
interface lpf_fir31_if;
    logic        ready;
    logic [7:0]  x;
    logic [4:0]  coeff_index;
    logic [9:0]  coeff;
    logic [17:0] y;
    logic        y_valid;
    logic        busy;
`ifdef FIR_OVERRUN_FLAG_EN
    logic        overrun;

    modport master (output ready, x, coeff, input coeff_index, y, y_valid, busy, overrun);
    modport slave  (input ready, x, coeff, output coeff_index, y, y_valid, busy, overrun);
`else
    modport master (output ready, x, coeff, input coeff_index, y, y_valid, busy);
    modport slave  (input ready, x, coeff, output coeff_index, y, y_valid, busy);
`endif
endinterface

// File: rtl/lpf_fir31.sv
// Sequential 31-tap low-pass FIR: one MAC per clock over a 32-entry circular sample history.
// Optional sticky overrun flag for strobes arriving while busy: define FIR_OVERRUN_FLAG_EN.
module lpf_fir31 (
    input  logic         clock,
    input  logic         reset_n,
    lpf_fir31_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [4:0]  wptr_r;
    logic [4:0]  base_r;
    logic [4:0]  idx_r;
    logic [17:0] acc_r;
    logic [17:0] y_r;
    logic        y_valid_r;
    logic        busy_r;
    logic [7:0]  buf_r [32];

    logic [4:0]  tap_addr_s;
    logic [7:0]  tap_s;
    logic [17:0] prod_s;
    logic [4:0]  coeff_index_s;

    // Next-state decode for the IDLE -> MAC -> DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.ready) state_nxt_s = MAC;
                else           state_nxt_s = IDLE;
            end
            MAC: begin
                if (idx_r == 5'd30) state_nxt_s = DONE;
                else                state_nxt_s = MAC;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_r <= IDLE;
        else          state_r <= state_nxt_s;
    end

    // Tap 0 is the newest sample; older taps walk backwards around the ring.
    always_comb begin
        tap_addr_s = base_r - idx_r;
        tap_s      = buf_r[tap_addr_s];
        prod_s     = {{10{tap_s[7]}}, tap_s} * {{8{bus.coeff[9]}}, bus.coeff};
        if (state_r == MAC) coeff_index_s = idx_r;
        else                coeff_index_s = 5'd0;
    end

    // Sample capture, multiply-accumulate and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) buf_r[i] <= 8'd0;
            wptr_r    <= 5'd0;
            base_r    <= 5'd0;
            idx_r     <= 5'd0;
            acc_r     <= 18'd0;
            y_r       <= 18'd0;
            y_valid_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.ready) begin
                        buf_r[wptr_r] <= bus.x;
                        base_r        <= wptr_r;
                        wptr_r        <= wptr_r + 5'd1;
                        acc_r         <= 18'd0;
                        idx_r         <= 5'd0;
                    end
                end
                MAC: begin
                    acc_r <= acc_r + prod_s;
                    idx_r <= idx_r + 5'd1;
                end
                DONE:    y_r <= acc_r;
                default: y_r <= y_r;
            endcase
            y_valid_r <= (state_r == DONE);
            busy_r    <= (state_nxt_s != IDLE);
        end
    end

`ifdef FIR_OVERRUN_FLAG_EN
    logic overrun_r;

    // Sticky record of any strobe that arrived while a computation was in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) overrun_r <= 1'b0;
        else          overrun_r <= overrun_r | (bus.ready & (state_r != IDLE));
    end

    assign bus.overrun = overrun_r;
`endif

    assign bus.coeff_index = coeff_index_s;
    assign bus.y           = y_r;
    assign bus.y_valid     = y_valid_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_lpf_fir31.sv
// Bench for lpf_fir31: supplies the coefficient ROM and checks every cycle against a convolution model.
module tb_lpf_fir31;
    logic clock;
    logic reset_n;
    lpf_fir31_if bus ();

    lpf_fir31 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int coef [32] = '{5, 6, 7, 10, 14, 19, 25, 31, 37, 43, 48, 53, 58, 61, 62, 63,
                      62, 61, 58, 53, 48, 43, 37, 31, 25, 19, 14, 10, 7, 6, 5, 0};

    int       n_cmp = 0;
    int       n_fail = 0;
    int       cyc = 0;
    int       last_acc = -1000;
    int       pend_m = 0;
    int       y_m = 0;
    logic     ov_m = 1'b0;
    int       hist [$];
    int       obs [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb bus.coeff = coef[bus.coeff_index][9:0];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Direct 31-tap convolution over every sample accepted since reset.
    function automatic int conv();
        int s = 0;
        int n = hist.size();
        for (int k = 0; k < 31; k++)
            if (n - 1 - k >= 0) s += coef[k] * hist[n - 1 - k];
        return s;
    endfunction

    function automatic int getobs(input int i);
        if (i < obs.size()) return obs[i];
        else                return -999999;
    endfunction

    task automatic step(input logic r, input logic [7:0] xv, input logic rn);
        logic exp_valid;
        logic exp_busy;
        int   exp_ci;
        bus.ready = r;
        bus.x     = xv;
        reset_n   = rn;
        if (!rn) begin
            hist.delete();
            last_acc = -1000;
            y_m      = 0;
            ov_m     = 1'b0;
            #1;
            chk("rst_busy", bus.busy, 0);
            chk("rst_y", $signed(bus.y), 0);
            chk("rst_y_valid", bus.y_valid, 0);
        end
        @(posedge clock);
        cyc++;
        if (rn && r) begin
            if (cyc - last_acc >= 33) begin
                hist.push_back(int'($signed(xv)));
                last_acc = cyc;
                pend_m   = conv();
            end else begin
                ov_m = 1'b1;
            end
        end
        @(negedge clock);
        exp_valid = (cyc == last_acc + 32);
        if (exp_valid) y_m = pend_m;
        exp_busy = (cyc >= last_acc) && (cyc < last_acc + 32);
        exp_ci   = (cyc >= last_acc && cyc <= last_acc + 30) ? cyc - last_acc : 0;
        chk("busy", bus.busy, exp_busy);
        chk("y_valid", bus.y_valid, exp_valid);
        chk("y", $signed(bus.y), y_m);
        chk("coeff_index", bus.coeff_index, exp_ci);
`ifdef FIR_OVERRUN_FLAG_EN
        chk("overrun", bus.overrun, ov_m);
`endif
        if (bus.y_valid) obs.push_back(int'($signed(bus.y)));
    endtask

    task automatic send(input logic [7:0] xv, input int gap);
        step(1'b1, xv, 1'b1);
        for (int i = 1; i < gap; i++) step(1'b0, 8'd0, 1'b1);
    endtask

    initial begin
        bus.ready = 1'b0;
        bus.x     = 8'd0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        repeat (3) step(1'b0, 8'd0, 1'b0);
        chk("reset_y_lit", $signed(bus.y), 0);
        chk("reset_ci_lit", bus.coeff_index, 0);

        // Impulse response, 40-cycle spacing.
        obs.delete();
        send(8'd127, 40);
        for (int i = 0; i < 31; i++) send(8'd0, 40);
        chk("imp_count", obs.size(), 32);
        chk("imp_y0", getobs(0), 635);
        chk("imp_y1", getobs(1), 762);
        chk("imp_y2", getobs(2), 889);
        chk("imp_peak", getobs(15), 8001);
        chk("imp_y30", getobs(30), 635);
        chk("imp_y31", getobs(31), 0);

        // Full-scale DC inputs.
        obs.delete();
        for (int i = 0; i < 31; i++) send(8'd64, 40);
        chk("dc64", getobs(30), 65344);
        obs.delete();
        for (int i = 0; i < 31; i++) send(8'h80, 40);
        chk("dcm128", getobs(30), -130688);
        chk("dcm128_busy_idle", bus.busy, 0);

        // Strobes during MAC and DONE are dropped; the first strobe after DONE is taken.
        obs.delete();
        step(1'b1, 8'd50, 1'b1);
        repeat (9) step(1'b0, 8'd0, 1'b1);
        step(1'b1, 8'd99, 1'b1);
        repeat (21) step(1'b0, 8'd0, 1'b1);
        step(1'b1, 8'd77, 1'b1);
        send(8'd33, 40);
        chk("drop_count", obs.size(), 2);
`ifdef FIR_OVERRUN_FLAG_EN
        chk("overrun_set", bus.overrun, 1);
`endif

        // Reset in the middle of MAC clears history and suppresses the result.
        step(1'b1, 8'd100, 1'b1);
        repeat (15) step(1'b0, 8'd0, 1'b1);
        repeat (3) step(1'b0, 8'd0, 1'b0);
`ifdef FIR_OVERRUN_FLAG_EN
        chk("overrun_clr", bus.overrun, 0);
`endif
        obs.delete();
        send(8'd127, 40);
        for (int i = 0; i < 15; i++) send(8'd0, 40);
        chk("rst_imp_count", obs.size(), 16);
        chk("rst_imp_y0", getobs(0), 635);
        chk("rst_imp_y1", getobs(1), 762);
        chk("rst_imp_peak", getobs(15), 8001);

        // Ramp across the write-pointer wrap.
        for (int k = 0; k < 40; k++) send(8'(k), 33 + int'($urandom_range(0, 5)));

        // Random samples, random spacing, random early strobes.
        for (int n = 0; n < 60; n++) begin
            int gap;
            int early;
            gap   = 33 + int'($urandom_range(0, 10));
            early = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 32)) : 0;
            step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
            for (int i = 1; i < gap; i++) step(i == early, 8'($urandom_range(0, 255)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
